// File: rtl/tcam_rule_install_ctrl_if.sv
// Bundle between the control plane, the lookup pipeline, the TCAM/action tables
// and the rule install controller.
//   slave  : controller side (takes requests and pipe_busy, drives table writes,
//            lookup_hold, completion and the install counter)
//   master : the surrounding logic / testbench side
//   req_*          : rule request (valid/ready, default flag, addr, key, mask, action)
//   pipe_busy      : lookup pipeline still holds an in-flight key
//   lookup_hold    : blocks new keys into the TCAM while an install runs
//   tcam_wr_*      : TCAM mask/key write port
//   action_wr_*    : action table write port plus default-action register write
//   done_valid/done_status : one-cycle completion pulse, 0 = ok, 1 = timeout
//   install_cnt    : wrapping count of successful installs
interface tcam_rule_install_ctrl_if #(
    parameter int unsigned KEY_W        = 128,
    parameter int unsigned ACTION_W     = 64,
    parameter int unsigned TCAM_ENTRIES = 16
);
    localparam int unsigned AW = (TCAM_ENTRIES > 1) ? $clog2(TCAM_ENTRIES) : 1;

    logic                req_valid;
    logic                req_ready;
    logic                req_default;
    logic [AW-1:0]       req_addr;
    logic [KEY_W-1:0]    req_key;
    logic [KEY_W-1:0]    req_mask;
    logic [ACTION_W-1:0] req_action;
    logic                pipe_busy;
    logic                lookup_hold;
    logic                tcam_wr_en;
    logic                tcam_wr_is_mask;
    logic [AW-1:0]       tcam_wr_addr;
    logic [KEY_W-1:0]    tcam_wr_data;
    logic                action_wr_en;
    logic                action_wr_default;
    logic [AW-1:0]       action_wr_addr;
    logic [ACTION_W-1:0] action_wr_data;
    logic [ACTION_W-1:0] action_default_data;
    logic                done_valid;
    logic                done_status;
    logic [15:0]         install_cnt;

    modport slave (
        input  req_valid, req_default, req_addr, req_key, req_mask, req_action, pipe_busy,
        output req_ready, lookup_hold,
        output tcam_wr_en, tcam_wr_is_mask, tcam_wr_addr, tcam_wr_data,
        output action_wr_en, action_wr_default, action_wr_addr, action_wr_data,
        output action_default_data, done_valid, done_status, install_cnt
    );

    modport master (
        output req_valid, req_default, req_addr, req_key, req_mask, req_action, pipe_busy,
        input  req_ready, lookup_hold,
        input  tcam_wr_en, tcam_wr_is_mask, tcam_wr_addr, tcam_wr_data,
        input  action_wr_en, action_wr_default, action_wr_addr, action_wr_data,
        input  action_default_data, done_valid, done_status, install_cnt
    );
endinterface

// File: rtl/tcam_rule_install_ctrl.sv
// Installs one TCAM rule (mask, key, action) or a default action without
// disturbing live lookups: it holds new keys off, waits for the lookup pipeline
// to drain for DRAIN_CYC consecutive idle cycles (bounded by TIMEOUT_CYC), then
// performs the table writes and reports completion.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : tcam_rule_install_ctrl_if slave modport (request, pipe status,
//         table write ports, completion and install counter)
module tcam_rule_install_ctrl #(
    parameter int unsigned KEY_W        = 128,
    parameter int unsigned ACTION_W     = 64,
    parameter int unsigned TCAM_ENTRIES = 16,
    parameter int unsigned DRAIN_CYC    = 4,
    parameter int unsigned TIMEOUT_CYC  = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    tcam_rule_install_ctrl_if.slave  bus
);
    localparam int unsigned AW     = (TCAM_ENTRIES > 1) ? $clog2(TCAM_ENTRIES) : 1;
    localparam int unsigned IDLE_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WR_MASK,
        S_WR_KEY,
        S_WR_ACT,
        S_DONE
    } state_e;

    state_e              state_q;
    logic                dflt_q;
    logic [AW-1:0]       addr_q;
    logic [KEY_W-1:0]    key_q;
    logic [KEY_W-1:0]    mask_q;
    logic [ACTION_W-1:0] action_q;
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;

    logic drain_done_c;
    logic timeout_c;

    // Drain is complete once DRAIN_CYC consecutive idle cycles have been counted.
    assign drain_done_c = (idle_cnt_q == IDLE_W'(DRAIN_CYC));
    // Timeout fires on the edge that would make the wait count reach TIMEOUT_CYC.
    assign timeout_c    = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));

    // Install sequencer; every output is a register set on the edge entering its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                 <= S_IDLE;
            dflt_q                  <= 1'b0;
            addr_q                  <= '0;
            key_q                   <= '0;
            mask_q                  <= '0;
            action_q                <= '0;
            idle_cnt_q              <= '0;
            wait_cnt_q              <= '0;
            bus.req_ready           <= 1'b1;
            bus.lookup_hold         <= 1'b0;
            bus.tcam_wr_en          <= 1'b0;
            bus.tcam_wr_is_mask     <= 1'b0;
            bus.tcam_wr_addr        <= '0;
            bus.tcam_wr_data        <= '0;
            bus.action_wr_en        <= 1'b0;
            bus.action_wr_default   <= 1'b0;
            bus.action_wr_addr      <= '0;
            bus.action_wr_data      <= '0;
            bus.action_default_data <= '0;
            bus.done_valid          <= 1'b0;
            bus.done_status         <= 1'b0;
            bus.install_cnt         <= '0;
        end else begin
            // Strobes are single-cycle; addr/data keep their last value.
            bus.tcam_wr_en        <= 1'b0;
            bus.tcam_wr_is_mask   <= 1'b0;
            bus.action_wr_en      <= 1'b0;
            bus.action_wr_default <= 1'b0;
            bus.done_valid        <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        dflt_q          <= bus.req_default;
                        addr_q          <= bus.req_addr;
                        key_q           <= bus.req_key;
                        mask_q          <= bus.req_mask;
                        action_q        <= bus.req_action;
                        idle_cnt_q      <= '0;
                        wait_cnt_q      <= '0;
                        bus.req_ready   <= 1'b0;
                        bus.lookup_hold <= 1'b1;
                        state_q         <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // A drained pipe wins over a simultaneous timeout.
                    if (drain_done_c) begin
                        if (dflt_q) begin
                            bus.action_wr_default   <= 1'b1;
                            bus.action_default_data <= action_q;
                            state_q                 <= S_WR_ACT;
                        end else begin
                            bus.tcam_wr_en      <= 1'b1;
                            bus.tcam_wr_is_mask <= 1'b1;
                            bus.tcam_wr_addr    <= addr_q;
                            bus.tcam_wr_data    <= mask_q;
                            state_q             <= S_WR_MASK;
                        end
                    end else if (timeout_c) begin
                        bus.done_valid  <= 1'b1;
                        bus.done_status <= 1'b1;
                        state_q         <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        idle_cnt_q <= bus.pipe_busy ? '0 : idle_cnt_q + IDLE_W'(1);
                    end
                end

                S_WR_MASK: begin
                    bus.tcam_wr_en   <= 1'b1;
                    bus.tcam_wr_data <= key_q;
                    state_q          <= S_WR_KEY;
                end

                S_WR_KEY: begin
                    bus.action_wr_en   <= 1'b1;
                    bus.action_wr_addr <= addr_q;
                    bus.action_wr_data <= action_q;
                    state_q            <= S_WR_ACT;
                end

                S_WR_ACT: begin
                    bus.done_valid  <= 1'b1;
                    bus.done_status <= 1'b0;
                    bus.install_cnt <= bus.install_cnt + 16'd1;
                    state_q         <= S_DONE;
                end

                S_DONE: begin
                    bus.req_ready   <= 1'b1;
                    bus.lookup_hold <= 1'b0;
                    state_q         <= S_IDLE;
                end

                default: begin
                    bus.req_ready   <= 1'b1;
                    bus.lookup_hold <= 1'b0;
                    state_q         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tcam_rule_install_ctrl.sv
// Self-checking bench for tcam_rule_install_ctrl: randomized requests and
// pipe_busy patterns compared against a transaction-level reference model.
module tb_tcam_rule_install_ctrl;
    localparam int KEY_W        = 128;
    localparam int ACTION_W     = 64;
    localparam int TCAM_ENTRIES = 16;
    localparam int DRAIN_CYC    = 4;
    localparam int TIMEOUT_CYC  = 1023;
    localparam int AW           = $clog2(TCAM_ENTRIES);

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tcam_rule_install_ctrl_if #(
        .KEY_W       (KEY_W),
        .ACTION_W    (ACTION_W),
        .TCAM_ENTRIES(TCAM_ENTRIES)
    ) tb_bus ();

    tcam_rule_install_ctrl #(
        .KEY_W       (KEY_W),
        .ACTION_W    (ACTION_W),
        .TCAM_ENTRIES(TCAM_ENTRIES),
        .DRAIN_CYC   (DRAIN_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(tb_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: last value seen on each write port and the install count.
    logic [AW-1:0]       m_taddr;
    logic [KEY_W-1:0]    m_tdata;
    logic [AW-1:0]       m_aaddr;
    logic [ACTION_W-1:0] m_adata;
    logic [ACTION_W-1:0] m_ddata;
    logic [15:0]         m_cnt;

    // Current transaction.
    bit                  t_dflt;
    logic [AW-1:0]       t_addr;
    logic [KEY_W-1:0]    t_key;
    logic [KEY_W-1:0]    t_mask;
    logic [ACTION_W-1:0] t_act;
    bit                  t_tout;
    int                  t_w;
    int                  t_d;
    bit                  t_busy [0:TIMEOUT_CYC+8];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_taddr = '0;
        m_tdata = '0;
        m_aaddr = '0;
        m_adata = '0;
        m_ddata = '0;
        m_cnt   = '0;
    endtask

    task automatic chk_outputs(input bit e_ready, input bit e_hold, input bit e_twen,
                               input bit e_tmask, input bit e_awen, input bit e_adef,
                               input bit e_dv);
        chk("req_ready",           128'(tb_bus.req_ready),           128'(e_ready));
        chk("lookup_hold",         128'(tb_bus.lookup_hold),         128'(e_hold));
        chk("tcam_wr_en",          128'(tb_bus.tcam_wr_en),          128'(e_twen));
        chk("tcam_wr_is_mask",     128'(tb_bus.tcam_wr_is_mask),     128'(e_tmask));
        chk("tcam_wr_addr",        128'(tb_bus.tcam_wr_addr),        128'(m_taddr));
        chk("tcam_wr_data",        128'(tb_bus.tcam_wr_data),        128'(m_tdata));
        chk("action_wr_en",        128'(tb_bus.action_wr_en),        128'(e_awen));
        chk("action_wr_addr",      128'(tb_bus.action_wr_addr),      128'(m_aaddr));
        chk("action_wr_data",      128'(tb_bus.action_wr_data),      128'(m_adata));
        chk("action_wr_default",   128'(tb_bus.action_wr_default),   128'(e_adef));
        chk("action_default_data", 128'(tb_bus.action_default_data), 128'(m_ddata));
        chk("done_valid",          128'(tb_bus.done_valid),          128'(e_dv));
        chk("install_cnt",         128'(tb_bus.install_cnt),         128'(m_cnt));
    endtask

    task automatic drive_noise();
        tb_bus.req_valid   = 1'($urandom);
        tb_bus.req_default = 1'($urandom);
        tb_bus.req_addr    = AW'($urandom);
        tb_bus.req_key     = {$urandom, $urandom, $urandom, $urandom};
        tb_bus.req_mask    = {$urandom, $urandom, $urandom, $urandom};
        tb_bus.req_action  = {$urandom, $urandom};
    endtask

    // Builds a request and its pipe_busy pattern, then predicts the write edge
    // (one edge after the first run of DRAIN_CYC idle cycles) and the done edge.
    // Modes: 0 idle pipe, 1 random, 2 busy every 3rd cycle then idle, 3 always busy.
    task automatic begin_txn(input bit dflt, input int mode, input int addr_sel);
        int run;
        int kfound;
        t_dflt = dflt;
        t_addr = (addr_sel < 0) ? AW'($urandom) : AW'(addr_sel);
        t_key  = {$urandom, $urandom, $urandom, $urandom};
        t_mask = {$urandom, $urandom, $urandom, $urandom};
        t_act  = {$urandom, $urandom};
        for (int k = 0; k <= TIMEOUT_CYC + 8; k++) begin
            case (mode)
                0:       t_busy[k] = 1'b0;
                1:       t_busy[k] = ($urandom_range(0, 9) < 4);
                2:       t_busy[k] = (k <= 12) && (k % 3 == 0);
                default: t_busy[k] = 1'b1;
            endcase
        end
        run    = 0;
        kfound = -1;
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            run = t_busy[k] ? 0 : run + 1;
            if (run == DRAIN_CYC && kfound < 0) kfound = k;
        end
        t_tout = (kfound < 0) || (kfound + 1 > TIMEOUT_CYC);
        t_w    = t_tout ? -100 : kfound + 1;
        t_d    = t_tout ? TIMEOUT_CYC : (dflt ? t_w + 1 : t_w + 3);
    endtask

    // Expected outputs after the k-th edge following acceptance.
    task automatic check_step(input int k);
        bit twen;
        bit tmask;
        bit awen;
        bit adef;
        bit dv;
        twen  = !t_tout && !t_dflt && (k == t_w || k == t_w + 1);
        tmask = !t_tout && !t_dflt && (k == t_w);
        awen  = !t_tout && !t_dflt && (k == t_w + 2);
        adef  = !t_tout && t_dflt && (k == t_w);
        dv    = (k == t_d);
        if (twen) begin
            m_taddr = t_addr;
            m_tdata = tmask ? t_mask : t_key;
        end
        if (awen) begin
            m_aaddr = t_addr;
            m_adata = t_act;
        end
        if (adef) m_ddata = t_act;
        if (dv && !t_tout) m_cnt = m_cnt + 16'd1;
        chk_outputs(k > t_d, k <= t_d, twen, tmask, awen, adef, dv);
        if (dv) chk("done_status", 128'(tb_bus.done_status), 128'(t_tout));
    endtask

    // Offers the prepared request, then runs and checks edges 1..last.
    task automatic run_txn(input int last);
        @(negedge clk);
        chk("ready_before_accept", 128'(tb_bus.req_ready), 128'(1));
        tb_bus.req_valid   = 1'b1;
        tb_bus.req_default = t_dflt;
        tb_bus.req_addr    = t_addr;
        tb_bus.req_key     = t_key;
        tb_bus.req_mask    = t_mask;
        tb_bus.req_action  = t_act;
        tb_bus.pipe_busy   = 1'($urandom);
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            drive_noise();
            tb_bus.pipe_busy = t_busy[k];
            @(posedge clk);
            #1;
            check_step(k);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tb_bus.req_valid = 1'b0;
            tb_bus.pipe_busy = 1'($urandom);
            @(posedge clk);
            #1;
            chk_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        tb_bus.req_valid   = 1'b0;
        tb_bus.req_default = 1'b0;
        tb_bus.req_addr    = '0;
        tb_bus.req_key     = '0;
        tb_bus.req_mask    = '0;
        tb_bus.req_action  = '0;
        tb_bus.pipe_busy   = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_done_status", 128'(tb_bus.done_status), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Normal install to entry 3 with an idle pipe.
        begin_txn(1'b0, 0, 3);
        chk("latency_normal", 128'(t_d), 128'(DRAIN_CYC + 4));
        run_txn(t_d + 1);

        // Default-action install with an idle pipe.
        begin_txn(1'b1, 0, -1);
        chk("latency_default", 128'(t_d), 128'(DRAIN_CYC + 2));
        run_txn(t_d + 1);
        idle_cycles(1);

        // Pipe busy every third cycle, then idle.
        begin_txn(1'b0, 2, -1);
        run_txn(t_d + 1);

        // Random requests and pipe activity, some back-to-back.
        for (int i = 0; i < 16; i++) begin
            begin_txn(1'($urandom), 1, -1);
            run_txn(t_d + 1);
            idle_cycles($urandom_range(0, 2));
        end

        // Pipe never drains: timeout with no writes.
        begin_txn(1'b0, 3, -1);
        run_txn(t_d + 1);
        idle_cycles(1);

        // Reset while the key write strobe is active.
        begin_txn(1'b0, 0, -1);
        run_txn(t_w + 1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst              = 1'b0;
        tb_bus.req_valid = 1'b0;
        idle_cycles(3);

        // Counter wrap across two back-to-back installs.
        @(negedge clk);
        tb_bus.req_valid = 1'b0;
        force tb_bus.install_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release tb_bus.install_cnt;
        m_cnt = 16'hFFFF;
        chk("install_cnt_preset", 128'(tb_bus.install_cnt), 128'(m_cnt));
        begin_txn(1'b0, 0, -1);
        run_txn(t_d + 1);
        chk("install_cnt_wrap", 128'(tb_bus.install_cnt), 128'(16'h0000));
        begin_txn(1'b0, 1, -1);
        run_txn(t_d + 1);
        chk("install_cnt_after_wrap", 128'(tb_bus.install_cnt), 128'(16'h0001));
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
